keypad_scanner: RTL and testbench
=================================

// Module: keypad_scanner
// PURPOSE
//   Reader side of the matrix-scan interface. The display drivers write a
//   matrix by strobing rows; this block reads a 4x4 key matrix. It drives one
//   column low at a time, senses the row lines, and debounces over whole scan
//   frames. Each clean key press produces one code pulse for the game
//   controller. It runs in the clk_1kHz domain, beside the button debouncers.
// PARAMETERS
//   SCAN_DIV        5  clk_1kHz cycles per column; one frame = 4*SCAN_DIV cycles.
//   DEBOUNCE_SCANS  3  consecutive identical frames needed to accept a change (>=2).
// PORTS
//   clk_1kHz     in   1  system clock.
//   btn_0_out    in   1  synchronous, active-high reset.
//   key_row      in   4  row sense lines, active-low (externally pulled up).
//   key_col      out  4  column drive, active-low, exactly one bit low at a time.
//   key_code     out  4  code of the accepted key, = col*4 + row; held until the next press.
//   key_valid    out  1  1-cycle pulse when a single key is accepted.
//   key_held     out  1  high while the accepted key stays pressed (debounced).
//   key_release  out  1  1-cycle pulse when the held key is released or becomes invalid.
//   multi_key    out  1  high while the debounced frame has 2 or more keys down.
// BEHAVIOUR
//   Reset values: key_col=4'b1110, key_code=0, key_valid=0, key_held=0,
//     key_release=0, multi_key=0.
//   Reset also clears col_idx, dwell_cnt, snapshot, prev_frame, deb_frame,
//     stable_cnt and the FSM state (IDLE).
//   Reset mid-operation aborts everything. A key still held after reset is
//     reported again as a fresh press once it has been debounced.
//   Scan
//   - dwell_cnt counts 0..SCAN_DIV-1. key_col = ~(4'b0001 << col_idx), registered.
//   - When dwell_cnt==SCAN_DIV-1, ~key_row is sampled into snap[col_idx*4 +: 4].
//     On the same edge dwell_cnt returns to 0 and col_idx advances (3 wraps to 0).
//   - The col-3 sample completes a frame. On that edge the 16-bit frame, which
//     includes the new col-3 bits, is registered and frame_strobe is set.
//   Debounce (on frame_strobe)
//   - If frame==prev_frame: stable_cnt = min(stable_cnt+1, DEBOUNCE_SCANS).
//   - Otherwise stable_cnt = 1.
//   - prev_frame is then updated to frame.
//   - When stable_cnt reaches DEBOUNCE_SCANS and frame!=deb_frame: deb_frame = frame
//     and deb_update is pulsed.
//   - A glitch shorter than DEBOUNCE_SCANS frames never reaches deb_frame.
//   FSM (evaluated on deb_update; outputs are registered)
//   - IDLE:  popcount(deb)==1 -> HELD: key_code=index, key_valid pulse, key_held=1.
//            popcount(deb)>=2 -> MULTI: multi_key=1.
//   - HELD:  deb==0 -> IDLE: key_release pulse, key_held=0.
//            deb nonzero but different from the held one-hot -> MULTI:
//            key_release pulse, key_held=0, multi_key=1.
//   - MULTI: deb==0 -> IDLE: multi_key=0. Any other frame stays in MULTI.
//            There is no rollover: a new key is accepted only after all keys
//            are released.
//   Latency: key_valid rises 2 cycles after the col-3 sample edge of the
//     DEBOUNCE_SCANS-th identical frame. With the defaults this is about
//     40-60 cycles after the press, depending on scan phase.
//   Pulses are exactly 1 cycle. key_valid and key_release are never high together.
// TESTING
//   Bench model: key_row[r]=0 iff key (c,r) is pressed and key_col[c]==0.
//   1 Reset, then idle 60 cycles -> key_col 1110,1101,1011,0111 every 5 cycles,
//     wrapping; all other outputs stay 0.
//   2 Hold key (col2,row1) clean -> one key_valid with key_code=9, key_held=1.
//     Release it -> one key_release 3 frames later, key_held=0, key_code stays 9.
//   3 Bounce key 6 (toggle every 7 cycles for 40 cycles, then steady) ->
//     exactly one key_valid with code 6.
//   4 Press keys 0 and 5 -> multi_key=1 and no key_valid. Release key 5 ->
//     multi_key stays 1. Release all -> multi_key=0. Press key 3 -> key_valid, code 3.
//   5 Pulse btn_0_out while key 12 is HELD -> all outputs at reset values next
//     cycle. Keep the key pressed -> a new key_valid with code 12 after debounce.
//   6 Press key 15 for exactly 1 frame (20 cycles), aligned to col0 ->
//     no key_valid and no multi_key.

Source files
------------

// File: rtl/keypad_scanner.sv
// 4x4 key matrix reader: walks one active-low column at a time, assembles
// 16-bit frames of the row sense lines, debounces whole frames and emits key events.
module keypad_scanner #(
    parameter int SCAN_DIV       = 5,
    parameter int DEBOUNCE_SCANS = 3
) (
    input  logic       clk_1kHz,
    input  logic       btn_0_out,
    input  logic [3:0] key_row,
    output logic [3:0] key_col,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held,
    output logic       key_release,
    output logic       multi_key,
    output logic [1:0] dbg_state
);

    localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int SW = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
    localparam logic [SW-1:0] STABLE_MAX = SW'(DEBOUNCE_SCANS);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HELD  = 2'd1,
        MULTI = 2'd2
    } state_t;

    logic [1:0]    col_idx;
    logic [DW-1:0] dwell_cnt;
    logic [15:0]   snap;
    logic [15:0]   frame;
    logic          frame_strobe;
    logic [15:0]   prev_frame;
    logic [15:0]   deb_frame;
    logic [SW-1:0] stable_cnt;
    logic [SW-1:0] stable_nxt;
    logic          deb_update;

    state_t      state, state_nxt;
    logic [3:0]  code_nxt;
    logic        valid_nxt, held_nxt, release_nxt, multi_nxt;
    logic [3:0]  deb_idx;
    logic [15:0] held_onehot;
    int          deb_ones;

    // Scan: the row sample for a column is taken on the last dwell cycle, so
    // the column drive has been stable for SCAN_DIV-1 cycles before sensing.
    always_ff @(posedge clk_1kHz) begin
        if (btn_0_out) begin
            col_idx      <= 2'd0;
            dwell_cnt    <= '0;
            key_col      <= 4'b1110;
            snap         <= 16'h0000;
            frame        <= 16'h0000;
            frame_strobe <= 1'b0;
        end else begin
            frame_strobe <= 1'b0;
            if (dwell_cnt == DWELL_LAST) begin
                dwell_cnt               <= '0;
                col_idx                 <= col_idx + 2'd1;
                key_col                 <= ~(4'b0001 << (col_idx + 2'd1));
                snap[{col_idx, 2'b00} +: 4] <= ~key_row;
                if (col_idx == 2'd3) begin
                    frame        <= {~key_row, snap[11:0]};
                    frame_strobe <= 1'b1;
                end
            end else begin
                dwell_cnt <= dwell_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        stable_nxt = {{(SW-1){1'b0}}, 1'b1};
        if (frame == prev_frame) begin
            stable_nxt = (stable_cnt >= STABLE_MAX) ? STABLE_MAX : stable_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk_1kHz) begin
        if (btn_0_out) begin
            prev_frame <= 16'h0000;
            deb_frame  <= 16'h0000;
            stable_cnt <= '0;
            deb_update <= 1'b0;
        end else begin
            deb_update <= 1'b0;
            if (frame_strobe) begin
                stable_cnt <= stable_nxt;
                prev_frame <= frame;
                if (stable_nxt == STABLE_MAX && frame != deb_frame) begin
                    deb_frame  <= frame;
                    deb_update <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        deb_idx = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (deb_frame[i]) deb_idx = 4'(i);
        end
    end

    assign deb_ones    = $countones(deb_frame);
    assign held_onehot = 16'h0001 << key_code;

    // Transitions only happen on a debounced change, so a frame that merely
    // repeats the current debounced state never produces an event.
    always_comb begin
        state_nxt   = state;
        code_nxt    = key_code;
        valid_nxt   = 1'b0;
        release_nxt = 1'b0;
        held_nxt    = key_held;
        multi_nxt   = multi_key;
        case (state)
            IDLE: begin
                if (deb_update) begin
                    if (deb_ones == 1) begin
                        state_nxt = HELD;
                        code_nxt  = deb_idx;
                        valid_nxt = 1'b1;
                        held_nxt  = 1'b1;
                    end else if (deb_ones >= 2) begin
                        state_nxt = MULTI;
                        multi_nxt = 1'b1;
                    end
                end
            end
            HELD: begin
                if (deb_update) begin
                    if (deb_frame == 16'h0000) begin
                        state_nxt   = IDLE;
                        release_nxt = 1'b1;
                        held_nxt    = 1'b0;
                    end else if (deb_frame != held_onehot) begin
                        state_nxt   = MULTI;
                        release_nxt = 1'b1;
                        held_nxt    = 1'b0;
                        multi_nxt   = 1'b1;
                    end
                end
            end
            MULTI: begin
                if (deb_update && deb_frame == 16'h0000) begin
                    state_nxt = IDLE;
                    multi_nxt = 1'b0;
                end
            end
            default: begin
                state_nxt = IDLE;
                held_nxt  = 1'b0;
                multi_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_1kHz) begin
        if (btn_0_out) begin
            state       <= IDLE;
            key_code    <= 4'd0;
            key_valid   <= 1'b0;
            key_held    <= 1'b0;
            key_release <= 1'b0;
            multi_key   <= 1'b0;
        end else begin
            state       <= state_nxt;
            key_code    <= code_nxt;
            key_valid   <= valid_nxt;
            key_held    <= held_nxt;
            key_release <= release_nxt;
            multi_key   <= multi_nxt;
        end
    end

    assign dbg_state = state;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: key matrix model, frame-history reference model
// checked every cycle, table-driven press vectors and hand-written corner sequences.
module tb_keypad_scanner;

    localparam int SCAN_DIV = 5;
    localparam int DEB      = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] key_row;
    logic [3:0] key_col;
    logic [3:0] key_code;
    logic       key_valid, key_held, key_release, multi_key;
    logic [1:0] dbg_state;
    logic [15:0] pressed = 16'h0000;

    always #5 clk = ~clk;

    // A row reads low when a pressed key sits in the column being driven low.
    always_comb begin
        key_row = 4'b1111;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (pressed[c*4 + r] && key_col[c] === 1'b0) key_row[r] = 1'b0;
            end
        end
    end

    keypad_scanner #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE_SCANS(DEB)) dut (
        .clk_1kHz    (clk),
        .btn_0_out   (rst),
        .key_row     (key_row),
        .key_col     (key_col),
        .key_code    (key_code),
        .key_valid   (key_valid),
        .key_held    (key_held),
        .key_release (key_release),
        .multi_key   (multi_key),
        .dbg_state   (dbg_state)
    );

    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: counts edges since reset, collects frames of pressed
    // keys, accepts a frame once the last DEB frames agree, outputs 2 edges later.
    int          m_cnt;
    logic [15:0] m_snap;
    logic [15:0] m_hist[$];
    logic [15:0] m_deb;
    int          m_state;
    logic [3:0]  m_code, m_col;
    logic        m_valid, m_held, m_release, m_multi;
    int          m_pend;
    logic [3:0]  p_code;
    logic        p_valid, p_held, p_release, p_multi;
    bit          chk_en = 0;

    task automatic model_event();
        int ones;
        int idx;
        ones = $countones(m_deb);
        idx = 0;
        for (int i = 0; i < 16; i++) if (m_deb[i]) idx = i;
        p_code = m_code; p_held = m_held; p_multi = m_multi;
        p_valid = 1'b0; p_release = 1'b0;
        if (m_state == 0) begin
            if (ones == 1) begin
                m_state = 1; p_code = 4'(idx); p_valid = 1'b1; p_held = 1'b1;
            end else if (ones >= 2) begin
                m_state = 2; p_multi = 1'b1;
            end
        end else if (m_state == 1) begin
            if (ones == 0) begin
                m_state = 0; p_release = 1'b1; p_held = 1'b0;
            end else if (!(ones == 1 && idx == int'(m_code))) begin
                m_state = 2; p_release = 1'b1; p_held = 1'b0; p_multi = 1'b1;
            end
        end else begin
            if (ones == 0) begin
                m_state = 0; p_multi = 1'b0;
            end
        end
        m_pend = 2;
    endtask

    always @(posedge clk) begin
        if (rst) begin
            m_cnt = 0; m_snap = 16'h0; m_deb = 16'h0; m_state = 0;
            m_code = 4'd0; m_valid = 0; m_held = 0; m_release = 0; m_multi = 0;
            m_pend = 0;
            m_hist.delete();
        end else begin
            m_valid = 1'b0;
            m_release = 1'b0;
            if (m_pend > 0) begin
                m_pend--;
                if (m_pend == 0) begin
                    m_code = p_code; m_valid = p_valid; m_held = p_held;
                    m_release = p_release; m_multi = p_multi;
                end
            end
            if (m_cnt % SCAN_DIV == SCAN_DIV - 1) begin
                int  col;
                bit  same;
                col = (m_cnt / SCAN_DIV) % 4;
                for (int r = 0; r < 4; r++) m_snap[col*4 + r] = pressed[col*4 + r];
                if (col == 3) begin
                    m_hist.push_back(m_snap);
                    if (m_hist.size() > DEB) void'(m_hist.pop_front());
                    same = (m_hist.size() == DEB);
                    foreach (m_hist[i]) if (m_hist[i] != m_snap) same = 0;
                    if (same && m_snap != m_deb) begin
                        m_deb = m_snap;
                        model_event();
                    end
                end
            end
            m_cnt++;
        end
        m_col = ~(4'b0001 << ((m_cnt / SCAN_DIV) % 4));
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("cycle_outputs",
                  {20'h0, key_col, key_code, key_valid, key_held, key_release, multi_key},
                  {20'h0, m_col, m_code, m_valid, m_held, m_release, m_multi});
        end
    end

    int         valid_cnt = 0;
    int         rel_cnt   = 0;
    bit         multi_seen = 0;
    logic [3:0] last_code = 4'd0;

    always @(negedge clk) begin
        if (key_valid === 1'b1) begin valid_cnt++; last_code = key_code; end
        if (key_release === 1'b1) rel_cnt++;
        if (multi_key === 1'b1) multi_seen = 1;
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clr();
        valid_cnt = 0; rel_cnt = 0; multi_seen = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    typedef struct {
        logic [15:0] keys;
        logic [3:0]  code;
        int          valids;
        bit          multi;
    } vec_t;

    vec_t tbl[5];

    initial begin
        logic [3:0] col_exp;

        tbl[0] = '{keys: 16'h0002, code: 4'd1,  valids: 1, multi: 1'b0};
        tbl[1] = '{keys: 16'h0100, code: 4'd8,  valids: 1, multi: 1'b0};
        tbl[2] = '{keys: 16'h8000, code: 4'd15, valids: 1, multi: 1'b0};
        tbl[3] = '{keys: 16'h0011, code: 4'd0,  valids: 0, multi: 1'b1};
        tbl[4] = '{keys: 16'h0001, code: 4'd0,  valids: 1, multi: 1'b0};

        // Reset and idle scan
        do_reset();
        chk_en = 1;
        clr();
        check("reset_code", {28'h0, key_code}, 32'h0);
        check("reset_flags", {28'h0, key_valid, key_held, key_release, multi_key}, 32'h0);
        for (int i = 0; i < 60; i++) begin
            col_exp = ~(4'b0001 << ((i / 5) % 4));
            check("idle_col", {28'h0, key_col}, {28'h0, col_exp});
            step(1);
        end
        check("idle_no_events", valid_cnt + rel_cnt + int'(multi_seen), 0);

        // Clean press and release of key 9
        clr();
        pressed = 16'h0200;
        step(100);
        check("k9_valid_cnt", valid_cnt, 1);
        check("k9_code", {28'h0, last_code}, 32'd9);
        check("k9_held", {31'h0, key_held}, 32'd1);
        pressed = 16'h0000;
        step(100);
        check("k9_release_cnt", rel_cnt, 1);
        check("k9_held_after", {31'h0, key_held}, 32'd0);
        check("k9_code_kept", {28'h0, key_code}, 32'd9);

        // Bouncing key 6
        clr();
        for (int i = 0; i < 40; i++) begin
            pressed = ((i / 7) % 2 == 0) ? 16'h0040 : 16'h0000;
            step(1);
        end
        pressed = 16'h0040;
        step(100);
        check("bounce_valid_cnt", valid_cnt, 1);
        check("bounce_code", {28'h0, last_code}, 32'd6);
        pressed = 16'h0000;
        step(100);

        // Two keys, partial release, full release, then a single key
        clr();
        pressed = 16'h0021;
        step(100);
        check("multi_on", {31'h0, multi_key}, 32'd1);
        check("multi_no_valid", valid_cnt, 0);
        pressed = 16'h0001;
        step(100);
        check("multi_stays", {31'h0, multi_key}, 32'd1);
        check("multi_no_rollover", valid_cnt, 0);
        pressed = 16'h0000;
        step(100);
        check("multi_off", {31'h0, multi_key}, 32'd0);
        pressed = 16'h0008;
        step(100);
        check("after_multi_valid", valid_cnt, 1);
        check("after_multi_code", {28'h0, last_code}, 32'd3);
        pressed = 16'h0000;
        step(100);

        // Reset while key 12 is held
        clr();
        pressed = 16'h1000;
        step(100);
        check("k12_held", {31'h0, key_held}, 32'd1);
        do_reset();
        check("midrst_col", {28'h0, key_col}, 32'he);
        check("midrst_outs", {27'h0, key_code, key_valid, key_held, key_release, multi_key}, 32'h0);
        clr();
        step(100);
        check("k12_revalid", valid_cnt, 1);
        check("k12_code", {28'h0, last_code}, 32'd12);
        pressed = 16'h0000;
        step(100);

        // Key 15 present for exactly one frame
        begin
            int guard;
            guard = 0;
            while (m_cnt % (4 * SCAN_DIV) != 0 && guard < 4 * SCAN_DIV) begin
                step(1);
                guard++;
            end
            check("frame_align", m_cnt % (4 * SCAN_DIV), 0);
        end
        clr();
        pressed = 16'h8000;
        step(4 * SCAN_DIV);
        pressed = 16'h0000;
        step(100);
        check("glitch_no_valid", valid_cnt, 0);
        check("glitch_no_multi", {31'h0, multi_seen}, 32'd0);

        // Table of single presses
        foreach (tbl[k]) begin
            clr();
            pressed = tbl[k].keys;
            step(100);
            check("tbl_valid_cnt", valid_cnt, tbl[k].valids);
            check("tbl_multi", {31'h0, multi_seen}, {31'h0, tbl[k].multi});
            if (tbl[k].valids > 0) check("tbl_code", {28'h0, last_code}, {28'h0, tbl[k].code});
            pressed = 16'h0000;
            step(100);
            check("tbl_release_cnt", rel_cnt, tbl[k].valids);
            check("tbl_idle", {30'h0, key_held, multi_key}, 32'h0);
        end

        // Random presses of zero to two keys and random hold times
        for (int n = 0; n < 30; n++) begin
            logic [15:0] pat;
            int nk;
            pat = 16'h0000;
            nk = $urandom_range(0, 2);
            for (int j = 0; j < nk; j++) pat[$urandom_range(0, 15)] = 1'b1;
            pressed = pat;
            step($urandom_range(5, 90));
        end
        pressed = 16'h0000;
        step(100);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
